// File: rtl/swc_pkg.sv
// Shared types and constants for the serial word collector.
package swc_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    PARITY  = 1'b1
  } swc_state_t;

  localparam int SWC_FIFO_DEPTH = 2;

endpackage

// File: rtl/swc_word_fifo2.sv
// Two-entry word buffer with registered head/valid/full; a push into a full
// buffer is only taken when a pop happens in the same cycle.
module swc_word_fifo2
  import swc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic             full
);

  // occ[0]: head entry valid, occ[1]: second entry valid
  logic [SWC_FIFO_DEPTH-1:0] occ;
  logic [WIDTH-1:0]          tail;
  logic                      pop_ok;

  assign pop_ok = pop && occ[0];
  assign valid  = occ[0];
  assign full   = occ[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      occ  <= '0;
      head <= '0;
    end else begin
      case (occ)
        2'b00: begin
          if (push) begin
            occ[0] <= 1'b1;
            head   <= push_data;
          end
        end
        2'b01: begin
          if (pop_ok && push) begin
            head <= push_data;
          end else if (pop_ok) begin
            occ[0] <= 1'b0;
          end else if (push) begin
            occ[1] <= 1'b1;
            tail   <= push_data;
          end
        end
        2'b11: begin
          // A push without a pop is dropped here; the caller flags it.
          if (pop_ok) begin
            head <= tail;
            if (push) tail <= push_data;
            else      occ[1] <= 1'b0;
          end
        end
        default: occ <= '0;
      endcase
    end
  end

endmodule

// File: rtl/serial_word_collector.sv
// Serial-to-word deserialiser with a 2-entry output buffer and sticky flags.
// Optional even-parity frame bit compiled in with `define SWC_PARITY_EN.
module serial_word_collector
  import swc_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  input  logic             ovf_clr,
  output logic             overflow,
  output logic             busy
`ifdef SWC_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic [WIDTH-1:0] push_data;
  logic [CNT_W-1:0] bit_cnt;
  logic             in_collect;
  logic             last_bit;
  logic             push;
  logic             pop;
  logic             full;
  logic             drop;

  always_comb begin
    if (MSB_FIRST) shreg_next = {shreg[WIDTH-2:0], bit_in};
    else           shreg_next = {bit_in, shreg[WIDTH-1:1]};
  end

`ifdef SWC_PARITY_EN
  swc_state_t state;
  logic       parity_bad;

  assign in_collect = (state == COLLECT);
  // The completed word waits in shreg while the parity bit is collected.
  assign push       = bit_valid && (state == PARITY);
  assign push_data  = shreg;
  assign parity_bad = ^{shreg, bit_in};
`else
  assign in_collect = 1'b1;
  assign push       = last_bit;
  assign push_data  = shreg_next;
`endif

  assign last_bit = in_collect && bit_valid && (bit_cnt == CNT_W'(WIDTH - 1));
  assign pop      = word_valid && word_ready;
  assign drop     = push && full && !pop;

  always_ff @(posedge clk) begin
    if (in_collect && bit_valid) shreg <= shreg_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt  <= '0;
      busy     <= 1'b0;
      overflow <= 1'b0;
`ifdef SWC_PARITY_EN
      state      <= COLLECT;
      parity_err <= 1'b0;
`endif
    end else begin
`ifdef SWC_PARITY_EN
      case (state)
        COLLECT: begin
          if (bit_valid) begin
            busy <= 1'b1;
            if (last_bit) begin
              bit_cnt <= '0;
              state   <= PARITY;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (bit_valid) begin
            busy  <= 1'b0;
            state <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
      if (push && parity_bad) parity_err <= 1'b1;
      else if (ovf_clr)       parity_err <= 1'b0;
`else
      if (bit_valid) begin
        if (last_bit) begin
          bit_cnt <= '0;
          busy    <= 1'b0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
          busy    <= 1'b1;
        end
      end
`endif
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  swc_word_fifo2 #(.WIDTH(WIDTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (word_out),
    .valid     (word_valid),
    .full      (full)
  );

endmodule

// File: doc/serial_word_collector.md
# serial_word_collector

Deserialiser that sits directly downstream of the 4-bit universal shift register. It samples the register's serial output bit (q[3] in shift-left mode, q[0] in shift-right mode) and assembles WIDTH-bit words. Completed words are held in a 2-entry output buffer and handed on over a valid/ready handshake. Words that arrive while the buffer is full are dropped and flagged.

## Interface
Parameters:
- WIDTH, 8, bits per word (2..32)
- MSB_FIRST, 1, 1: first received bit lands in word[WIDTH-1]; 0: first bit lands in word[0]

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  reset, synchronous, active-high
- bit_in  in  1  serial data bit
- bit_valid  in  1  bit_in is sampled this cycle
- word_out  out  WIDTH  head-of-buffer word
- word_valid  out  1  word_out holds a valid word
- word_ready  in  1  consumer accepts word_out this cycle
- ovf_clr  in  1  clears the overflow flag
- overflow  out  1  sticky: at least one completed word was dropped
- busy  out  1  a partial word is in progress (bit count ≠ 0, or in PARITY)
- parity_err  out  1  present only with PARITY_EN; sticky, cleared by ovf_clr

## Operation
- FSM states: COLLECT, PARITY (PARITY exists only with PARITY_EN).
- COLLECT:
  - Each bit_valid cycle shifts bit_in into the assembly register and increments bit_cnt (width $clog2(WIDTH+1)).
  - MSB_FIRST=1: shift left, new bit enters at LSB. MSB_FIRST=0: shift right, new bit enters at MSB.
  - When the WIDTH-th bit is sampled, bit_cnt returns to 0 and the word completes. Without PARITY_EN it is pushed the same cycle. With PARITY_EN the FSM goes to PARITY instead.
- PARITY: the next bit_valid bit is the even-parity bit and the word is pushed. On mismatch, parity_err is set (the word is still pushed). FSM returns to COLLECT.
- Buffer:
  - 2-entry FIFO. Push = word completion; pop = word_valid && word_ready.
  - A push in a cycle with a simultaneous pop on a full buffer is accepted.
  - A push on a full buffer with no pop is dropped, overflow is set, and assembly continues with the next bit.
- Flags:
  - ovf_clr clears overflow and parity_err.
  - If a set event and ovf_clr occur in the same cycle, set wins.
- bit_valid gaps of any length are allowed; partial state is held.

## Timing
- Reset values: word_out=0, word_valid=0, overflow=0, busy=0, parity_err=0. FSM=COLLECT, bit_cnt=0, buffer empty.
- rst mid-word discards the partial word and all buffered words.
- Latency: word_valid rises the cycle after the final bit (data bit, or parity bit with PARITY_EN) is sampled, when the buffer was empty.
- word_out/word_valid come straight from registers. word_out is stable while word_valid=1 and word_ready=0.
- Throughput: one bit per cycle with no bubbles. A word every WIDTH cycles (WIDTH+1 with PARITY_EN) when word_ready is held high.
- busy is registered: it rises the cycle after the first bit and falls the cycle after completion.

## Configuration
- SWC_PARITY_EN defined:
  - PARITY state, parity_err port and parity check are compiled in.
  - Each frame is WIDTH data bits plus one even-parity bit.
- SWC_PARITY_EN undefined:
  - No PARITY state and no parity_err port.
  - Frames are exactly WIDTH bits.

## Structure
- Shared package swc_pkg:
  - FSM state typedef (COLLECT, PARITY)
  - SWC_FIFO_DEPTH=2
- Sub-module swc_word_fifo2:
  - Parameterised by WIDTH.
  - Ports: push, push_data, pop, head, valid, full.
  - Implements the simultaneous push/pop-when-full rule.
- Top level holds the FSM, shift/count logic and flags.

## Test plan
- WIDTH=8, MSB_FIRST=1, bits 1,0,1,1,0,0,1,0 on consecutive cycles, word_ready=1 -> word_out=8'hB2, word_valid high for exactly one cycle, one cycle after the last bit.
- Same bit stream with MSB_FIRST=0 -> word_out=8'h4D.
- word_ready=0 while 3 words (8'h11, 8'h22, 8'h33) are sent -> buffer holds 8'h11 then 8'h22, 8'h33 is dropped, overflow=1. Then pulse ovf_clr -> overflow=0.
- Full buffer; final bit of 8'h44 arrives in the same cycle as a pop -> 8'h44 is accepted, overflow stays 0, and the output order is 8'h22, 8'h44.
- Assert rst after 5 bits of a word, then send 8'hA5 -> only 8'hA5 appears and busy=0 after completion.
- With SWC_PARITY_EN: send 8'hB2 plus parity bit 1 (wrong; even parity needs 0) -> 8'hB2 is delivered and parity_err=1. Then 8'h03 plus parity bit 0 -> parity_err stays 1 until ovf_clr.
